seg_scan_controller: RTL and testbench

Time-multiplexes NUM_DIGITS common-anode 7-segment digits through one shared led_number_decoder instance. Holds a per-digit value/blank register file, loaded through a valid/ready write port. Sequences digit selection with a refresh prescaler and an all-off dead-time gap between digits to stop ghosting. Sits between game-control logic (score, level, "L" indicator) and the board's segment/anode pins.

---
 rtl/seg_scan_controller.sv | 196 +++++++++++++++++++
 tb/tb_seg_scan_controller.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_controller
// Description : Time-multiplexed driver for NUM_DIGITS common-anode 7-segment
//               digits sharing one external led_number_decoder. Holds a
//               per-digit value/blank register file written through a
//               valid/ready port, scans the digits with a refresh prescaler,
//               and inserts an all-off dead-time gap between digits so the
//               previous digit's segments never ghost onto the next anode.
// Options     : `define SEG_BLINK_EN adds the blink_mask input and a
//               free-running blink phase that blanks masked digits on
//               alternate BLINK_DIV-cycle half periods.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 16,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_digit,
  input  logic [3:0]                    wr_value,
  input  logic                          wr_blank,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]         blink_mask,
`endif
  output logic [3:0]                    dec_num,
  input  logic [7:0]                    dec_leds,
  output logic [7:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int C_IDX_W   = $clog2(NUM_DIGITS);
  localparam int C_CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;

  localparam logic [C_CNT_W-1:0] C_DRIVE_END = C_CNT_W'(REFRESH_DIV - 1);
  localparam logic [C_CNT_W-1:0] C_GAP_END   = C_CNT_W'(GAP_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

  localparam logic [C_IDX_W-1:0] C_LAST_IDX  = C_IDX_W'(NUM_DIGITS - 1);
  localparam logic [C_IDX_W-1:0] C_IDX_ONE   = C_IDX_W'(1);
  localparam logic [C_IDX_W:0]   C_NUM_DIGITS_EXT = (C_IDX_W + 1)'(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] C_AN_ONE = {{(NUM_DIGITS - 1){1'b0}}, 1'b1};

  // Scan FSM encoding
  localparam logic [0:0] C_ST_GAP   = 1'b0;
  localparam logic [0:0] C_ST_DRIVE = 1'b1;

  // Reject illegal configurations at elaboration time
  if ((NUM_DIGITS < 2) || (NUM_DIGITS > 8) || (REFRESH_DIV < 2) ||
      (GAP_CYCLES < 1) || (BLINK_DIV < 1)) begin : g_param_check
    $error("seg_scan_controller: illegal parameter value");
  end

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [0:0]            r_state;
  logic [C_CNT_W-1:0]    r_cnt;
  logic [C_IDX_W-1:0]    r_scan_idx;
  logic [3:0]            r_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_blank;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic w_drive;
  logic w_wr_conflict;
  logic w_wr_accept;
  logic w_wr_in_range;
  logic w_force_blank;
  logic w_digit_blank;

  assign w_drive = (r_state == C_ST_DRIVE);

  // The lit digit may not be rewritten while it is on the pins, so a write
  // aimed at it stalls until the dead-time gap that follows.
  assign w_wr_conflict = w_drive && (wr_digit == r_scan_idx);
  assign wr_ready      = reset_n & ~w_wr_conflict;
  assign w_wr_accept   = wr_valid & wr_ready;

  // Indices past the last digit are swallowed without touching storage.
  assign w_wr_in_range = ({1'b0, wr_digit} < C_NUM_DIGITS_EXT);

  // The shared decoder always sees the digit currently selected.
  assign dec_num  = r_val[r_scan_idx];
  assign scan_idx = r_scan_idx;
  assign seg_out  = r_seg;
  assign an_out   = r_an;

`ifdef SEG_BLINK_EN
  localparam int C_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [C_BLINK_W-1:0] C_BLINK_END = C_BLINK_W'(BLINK_DIV - 1);
  localparam logic [C_BLINK_W-1:0] C_BLINK_ONE = C_BLINK_W'(1);

  logic [C_BLINK_W-1:0] r_blink_cnt;
  logic                 r_blink_phase;

  // Free-running blink timebase, independent of the scan position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == C_BLINK_END) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + C_BLINK_ONE;
    end
  end

  // Masked digits go dark in the "off" half period; anode timing is untouched
  assign w_force_blank = r_blink_phase & blink_mask[r_scan_idx];
`else
  assign w_force_blank = 1'b0;
`endif

  assign w_digit_blank = r_blank[r_scan_idx] | w_force_blank;

  // --------------------------------------------------------------------------
  // Scan sequencer: GAP (all off) -> DRIVE (one digit lit) -> next digit
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= C_ST_GAP;
      r_cnt      <= '0;
      r_scan_idx <= '0;
    end else begin
      case (r_state)
        C_ST_GAP: begin
          if (r_cnt == C_GAP_END) begin
            r_state <= C_ST_DRIVE;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + C_CNT_ONE;
          end
        end
        C_ST_DRIVE: begin
          if (r_cnt == C_DRIVE_END) begin
            r_state    <= C_ST_GAP;
            r_cnt      <= '0;
            r_scan_idx <= (r_scan_idx == C_LAST_IDX) ? '0 : (r_scan_idx + C_IDX_ONE);
          end else begin
            r_cnt      <= r_cnt + C_CNT_ONE;
          end
        end
        default: begin
          r_state <= C_ST_GAP;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-digit value/blank storage, written on an accepted in-range request
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_val[i] <= 4'h0;
      end
      r_blank <= '1;
    end else if (w_wr_accept && w_wr_in_range) begin
      r_val[wr_digit]   <= wr_value;
      r_blank[wr_digit] <= wr_blank;
    end
  end

  // --------------------------------------------------------------------------
  // Registered pin drive: one clk behind the sequencer state, all-off in GAP
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg <= 8'h00;
      r_an  <= '1;
    end else if (w_drive) begin
      r_seg <= w_digit_blank ? 8'h00 : dec_leds;
      r_an  <= ~(C_AN_ONE << r_scan_idx);
    end else begin
      r_seg <= 8'h00;
      r_an  <= '1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_controller
// Description : Self-checking bench for seg_scan_controller. A 4-digit
//               instance is tracked by a position-arithmetic reference model
//               with randomized writes; a 5-digit instance exercises
//               out-of-range digit indices.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_controller;

  localparam int ND  = 4;
  localparam int RD  = 8;
  localparam int GC  = 2;
  localparam int PER = ND * (RD + GC);

  localparam int ND5  = 5;
  localparam int RD5  = 4;
  localparam int GC5  = 1;
  localparam int PER5 = ND5 * (RD5 + GC5);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // 4-digit instance
  logic       wr_valid, wr_ready, wr_blank;
  logic [1:0] wr_digit, scan_idx;
  logic [3:0] wr_value, dec_num, an_out;
  logic [7:0] dec_leds, seg_out;

  // 5-digit instance
  logic       wr_valid5, wr_ready5, wr_blank5;
  logic [2:0] wr_digit5, scan_idx5;
  logic [3:0] wr_value5, dec_num5;
  logic [4:0] an_out5;
  logic [7:0] dec_leds5, seg_out5;

  int vectors    = 0;
  int miscompares = 0;

  // External decoder: gfedcba, active-high; 4'hF renders as "L"
  function automatic logic [7:0] seg_font(input logic [3:0] v);
    case (v)
      4'h0: return 8'h3F; 4'h1: return 8'h06; 4'h2: return 8'h5B; 4'h3: return 8'h4F;
      4'h4: return 8'h66; 4'h5: return 8'h6D; 4'h6: return 8'h7D; 4'h7: return 8'h07;
      4'h8: return 8'h7F; 4'h9: return 8'h6F; 4'hA: return 8'h77; 4'hB: return 8'h7C;
      4'hC: return 8'h39; 4'hD: return 8'h5E; 4'hE: return 8'h79; default: return 8'h38;
    endcase
  endfunction

  assign dec_leds  = seg_font(dec_num);
  assign dec_leds5 = seg_font(dec_num5);

  seg_scan_controller #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GAP_CYCLES(GC), .BLINK_DIV(20)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_digit(wr_digit),
    .wr_value(wr_value), .wr_blank(wr_blank),
`ifdef SEG_BLINK_EN
    .blink_mask(4'b0000),
`endif
    .dec_num(dec_num), .dec_leds(dec_leds),
    .seg_out(seg_out), .an_out(an_out), .scan_idx(scan_idx)
  );

  seg_scan_controller #(.NUM_DIGITS(ND5), .REFRESH_DIV(RD5), .GAP_CYCLES(GC5), .BLINK_DIV(20)) dut5 (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid5), .wr_ready(wr_ready5), .wr_digit(wr_digit5),
    .wr_value(wr_value5), .wr_blank(wr_blank5),
`ifdef SEG_BLINK_EN
    .blink_mask(5'b00000),
`endif
    .dec_num(dec_num5), .dec_leds(dec_leds5),
    .seg_out(seg_out5), .an_out(an_out5), .scan_idx(scan_idx5)
  );

  // --------------------------------------------------------------------------
  // Reference model for the 4-digit instance. m_k counts clock edges since
  // reset release; scan position follows from it arithmetically.
  // --------------------------------------------------------------------------
  int         m_k;
  logic [3:0] m_val [ND];
  bit         m_blank [ND];
  logic [7:0] m_seg;
  logic [3:0] m_an;

  function automatic int m_digit();
    return (m_k % PER) / (RD + GC);
  endfunction

  function automatic bit m_drive();
    return ((m_k % PER) % (RD + GC)) >= GC;
  endfunction

  function automatic bit m_ready();
    return !(m_drive() && (int'(wr_digit) == m_digit()));
  endfunction

  function automatic logic [17:0] m_vec();
    return {m_an, m_seg, 2'(m_digit()), m_val[m_digit()]};
  endfunction

  task automatic m_reset();
    m_k = 0;
    for (int i = 0; i < ND; i++) begin
      m_val[i]   = 4'h0;
      m_blank[i] = 1'b1;
    end
    m_seg = 8'h00;
    m_an  = 4'hF;
  endtask

  // Advance one clock from a negedge to the next negedge, tracking any write
  task automatic adv();
    bit         acc;
    logic [7:0] nseg;
    logic [3:0] nan;
    int         d;
    d   = m_digit();
    acc = wr_valid && m_ready();
    if (m_drive()) begin
      nan    = 4'hF;
      nan[d] = 1'b0;
      nseg   = m_blank[d] ? 8'h00 : seg_font(m_val[d]);
    end else begin
      nan  = 4'hF;
      nseg = 8'h00;
    end
    @(posedge clk);
    if (acc) begin
      m_val[wr_digit]   = wr_value;
      m_blank[wr_digit] = wr_blank;
    end
    m_seg = nseg;
    m_an  = nan;
    m_k++;
    @(negedge clk);
  endtask

  // Present a write and hold it until the model says it is taken
  task automatic do_write(input int d, input logic [3:0] v, input bit b);
    int guard;
    guard    = 0;
    wr_valid = 1'b1;
    wr_digit = 2'(d);
    wr_value = v;
    wr_blank = b;
    #1;
    while (!m_ready() && guard < 100) begin
      adv();
      #1;
      guard++;
    end
    adv();
    wr_valid = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({an_out, seg_out, scan_idx, dec_num, wr_ready} !== {4'hF, 8'h00, 2'd0, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got an=%b seg=%h idx=%0d num=%h rdy=%b, want an=1111 seg=00 idx=0 num=0 rdy=0",
               an_out, seg_out, scan_idx, dec_num, wr_ready);
    end
    reset_n = 1'b1;
    m_reset();
    #1;
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 1", wr_ready);
    end
  endtask

  task automatic test_blank_scan();
    for (int c = 0; c < 2 * PER + 2; c++) begin
      vectors++;
      if ({an_out, seg_out, scan_idx, dec_num} !== m_vec()) begin
        miscompares++;
        $display("FAIL blank_scan k=%0d: got %h want %h", m_k, {an_out, seg_out, scan_idx, dec_num}, m_vec());
      end
      adv();
    end
  endtask

  task automatic test_digit_values();
    do_write(0, 4'h3, 1'b0);
    do_write(3, 4'hF, 1'b0);
    for (int c = 0; c < 2 * PER; c++) begin
      vectors++;
      if ({an_out, seg_out, scan_idx, dec_num} !== m_vec()) begin
        miscompares++;
        $display("FAIL digit_values k=%0d: got %h want %h", m_k, {an_out, seg_out, scan_idx, dec_num}, m_vec());
      end
      if (an_out == 4'b1110) begin
        vectors++;
        if (seg_out !== 8'b01001111) begin
          miscompares++;
          $display("FAIL digit0_three: got %b want 01001111", seg_out);
        end
      end
      if (an_out == 4'b0111) begin
        vectors++;
        if (seg_out !== 8'b00111000) begin
          miscompares++;
          $display("FAIL digit3_L: got %b want 00111000", seg_out);
        end
      end
      adv();
    end
  endtask

  task automatic test_write_conflict();
    int guard;
    int lit;
    guard = 0;
    while (!(m_drive() && m_digit() == 1) && guard < PER + 2) begin
      adv();
      guard++;
    end
    adv();
    adv();
    wr_valid = 1'b1;
    wr_digit = 2'd1;
    wr_value = 4'h5;
    wr_blank = 1'b0;
    #1;
    vectors++;
    if (wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_stall: got ready=%b want 0", wr_ready);
    end
    guard = 0;
    while (!m_ready() && guard < RD + 4) begin
      vectors++;
      if (wr_ready !== m_ready()) begin
        miscompares++;
        $display("FAIL conflict_hold k=%0d: got ready=%b want %b", m_k, wr_ready, m_ready());
      end
      adv();
      #1;
      guard++;
    end
    vectors++;
    if (wr_ready !== 1'b1 || m_drive()) begin
      miscompares++;
      $display("FAIL conflict_release k=%0d: got ready=%b want 1 in gap", m_k, wr_ready);
    end
    adv();
    wr_valid = 1'b0;
    lit = 0;
    for (int c = 0; c < PER + 2; c++) begin
      vectors++;
      if ({an_out, seg_out, scan_idx, dec_num} !== m_vec()) begin
        miscompares++;
        $display("FAIL conflict_scan k=%0d: got %h want %h", m_k, {an_out, seg_out, scan_idx, dec_num}, m_vec());
      end
      if (an_out == 4'b1101) begin
        lit++;
        vectors++;
        if (seg_out !== 8'b01101101) begin
          miscompares++;
          $display("FAIL conflict_newval: got %b want 01101101", seg_out);
        end
      end
      adv();
    end
    vectors++;
    if (lit != RD) begin
      miscompares++;
      $display("FAIL conflict_dwell: got %0d lit cycles want %0d", lit, RD);
    end
  endtask

  task automatic test_random();
    bit pending;
    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      vectors++;
      if ({an_out, seg_out, scan_idx, dec_num} !== m_vec()) begin
        miscompares++;
        $display("FAIL random_pins k=%0d: got %h want %h", m_k, {an_out, seg_out, scan_idx, dec_num}, m_vec());
      end
      if (!pending && ($urandom % 3 == 0)) begin
        wr_valid = 1'b1;
        wr_digit = 2'($urandom % ND);
        wr_value = 4'($urandom);
        wr_blank = ($urandom % 4 == 0);
        pending  = 1'b1;
      end
      #1;
      vectors++;
      if (wr_ready !== m_ready()) begin
        miscompares++;
        $display("FAIL random_ready k=%0d: got %b want %b", m_k, wr_ready, m_ready());
      end
      if (pending && m_ready()) begin
        adv();
        wr_valid = 1'b0;
        pending  = 1'b0;
      end else begin
        adv();
      end
    end
  endtask

  task automatic test_reset_mid_drive();
    int guard;
    guard = 0;
    do_write(0, 4'h8, 1'b0);
    while (!(m_drive() && m_digit() == 0) && guard < PER + 2) begin
      adv();
      guard++;
    end
    adv();
    adv();
    vectors++;
    if ({an_out, seg_out} !== {4'b1110, 8'h7F}) begin
      miscompares++;
      $display("FAIL pre_reset_lit: got an=%b seg=%h want an=1110 seg=7f", an_out, seg_out);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({an_out, seg_out, scan_idx, dec_num, wr_ready} !== {4'hF, 8'h00, 2'd0, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got an=%b seg=%h idx=%0d num=%h rdy=%b, want an=1111 seg=00 idx=0 num=0 rdy=0",
               an_out, seg_out, scan_idx, dec_num, wr_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    for (int c = 0; c <= GC + 3; c++) begin
      vectors++;
      if ({an_out, seg_out, scan_idx, dec_num} !== m_vec()) begin
        miscompares++;
        $display("FAIL post_reset k=%0d: got %h want %h", m_k, {an_out, seg_out, scan_idx, dec_num}, m_vec());
      end
      if (c == GC + 1) begin
        vectors++;
        if ({an_out, seg_out} !== {4'b1110, 8'h00}) begin
          miscompares++;
          $display("FAIL first_lit_after_reset: got an=%b seg=%h want an=1110 seg=00", an_out, seg_out);
        end
      end
      adv();
    end
  endtask

  task automatic test_out_of_range();
    int guard;
    int hits;
    for (int d = 5; d < 8; d++) begin
      wr_valid5 = 1'b1;
      wr_digit5 = 3'(d);
      wr_value5 = 4'h1;
      wr_blank5 = 1'b0;
      #1;
      vectors++;
      if (wr_ready5 !== 1'b1) begin
        miscompares++;
        $display("FAIL oor_ready digit=%0d: got %b want 1", d, wr_ready5);
      end
      @(negedge clk);
    end
    wr_digit5 = 3'd4;
    wr_value5 = 4'h8;
    #1;
    guard = 0;
    while (wr_ready5 !== 1'b1 && guard < RD5 + 4) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(negedge clk);
    wr_valid5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    hits = 0;
    for (int c = 0; c < 2 * PER5 + 2; c++) begin
      vectors++;
      if (seg_out5 !== ((an_out5 == 5'b01111) ? 8'h7F : 8'h00)) begin
        miscompares++;
        $display("FAIL oor_display an=%b: got seg=%h want %h", an_out5, seg_out5,
                 (an_out5 == 5'b01111) ? 8'h7F : 8'h00);
      end
      if (an_out5 == 5'b01111) hits++;
      @(negedge clk);
    end
    vectors++;
    if (hits != 2 * RD5) begin
      miscompares++;
      $display("FAIL oor_digit4_dwell: got %0d lit cycles want %0d", hits, 2 * RD5);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_valid  = 1'b0; wr_digit  = '0; wr_value  = '0; wr_blank  = 1'b0;
    wr_valid5 = 1'b0; wr_digit5 = '0; wr_value5 = '0; wr_blank5 = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_blank_scan();
    test_digit_values();
    test_write_conflict();
    test_random();
    test_reset_mid_drive();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
